// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode and compare-condition encodings, flag bit positions
// and the signed/unsigned less-than helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNor   = 4'd5,
    OpSll   = 4'd6,
    OpSrl   = 4'd7,
    OpSra   = 4'd8,
    OpSlt   = 4'd9,
    OpMult  = 4'd10,
    OpDiv   = 4'd11,
    OpLui   = 4'd12,
    OpPassA = 4'd13,
    OpPassB = 4'd14,
    OpCmp   = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    CmpEq = 3'd0,
    CmpNe = 3'd1,
    CmpLt = 3'd2,
    CmpLe = 3'd3,
    CmpGt = 3'd4,
    CmpGe = 3'd5
  } cmp_e;

  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  function automatic logic less_than(input logic [31:0] a, input logic [31:0] b,
                                     input logic is_signed);
    return is_signed ? ($signed(a) < $signed(b)) : (a < b);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Multiply/divide datapath with the HI/LO registers. Division is built only when
// ALU_DIV_EN is defined; otherwise the divide request is ignored.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        mul_en_i,
  input  logic        div_en_i,
  input  logic        signed_i,
  output logic [31:0] res_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] quot, rem;
  logic        div_vld;
  logic [31:0] hi_d, hi_q, lo_d, lo_q;

  // Extending to 64 bits first makes one unsigned multiply serve both signednesses.
  assign a_ext = {{32{signed_i & a_i[31]}}, a_i};
  assign b_ext = {{32{signed_i & b_i[31]}}, b_i};
  assign prod  = a_ext * b_ext;

`ifdef ALU_DIV_EN
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;

  // Divide magnitudes and fix signs afterwards; avoids the INT_MIN / -1 corner.
  assign a_neg   = signed_i & a_i[31];
  assign b_neg   = signed_i & b_i[31];
  assign a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
  assign b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
  assign b_zero  = (b_i == 32'd0);
  assign b_div   = b_zero ? 32'd1 : b_mag;
  assign q_mag   = a_mag / b_div;
  assign r_mag   = a_mag % b_div;
  assign quot    = b_zero ? 32'hFFFF_FFFF : ((a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag);
  assign rem     = b_zero ? a_i : (a_neg ? (~r_mag + 32'd1) : r_mag);
  assign div_vld = div_en_i;
`else
  logic unused_div;
  assign unused_div = div_en_i;
  assign quot       = 32'd0;
  assign rem        = 32'd0;
  assign div_vld    = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_en_i) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end else if (div_vld) begin
      hi_d = rem;
      lo_d = quot;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign res_o = mul_en_i ? prod[31:0] : quot;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule

// File: rtl/alu.sv
// 32-bit ALU: combinational result and {Z,N,C,V} flags, registered HI/LO via alu_muldiv.
// Opcode 11 (DIV) is active only when ALU_DIV_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  operation,
  input  logic [1:0]  sign,
  input  logic [2:0]  cmpSignal,
  output logic [31:0] Y,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [3:0]  carryFlags
);

  logic        is_signed, unused_sign;
  logic [32:0] sum, diff;
  logic        lt, eq, cmp_hit, c_flag, v_flag;
  logic [31:0] md_res;

  assign is_signed   = sign[0];
  assign unused_sign = sign[1];

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} + {1'b0, ~B} + 33'd1;
  assign lt   = less_than(A, B, is_signed);
  assign eq   = (A == B);

  alu_muldiv u_muldiv (
    .clk_i    (Clk),
    .rst_i    (reset),
    .a_i      (A),
    .b_i      (B),
    .mul_en_i (operation == OpMult),
    .div_en_i (operation == OpDiv),
    .signed_i (is_signed),
    .res_o    (md_res),
    .hi_o     (HI),
    .lo_o     (LO)
  );

  always_comb begin
    cmp_hit = 1'b0;
    case (cmp_e'(cmpSignal))
      CmpEq:   cmp_hit = eq;
      CmpNe:   cmp_hit = !eq;
      CmpLt:   cmp_hit = lt;
      CmpLe:   cmp_hit = lt | eq;
      CmpGt:   cmp_hit = !(lt | eq);
      CmpGe:   cmp_hit = !lt;
      default: cmp_hit = 1'b0;
    endcase
  end

  always_comb begin
    Y      = 32'd0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (alu_op_e'(operation))
      OpAdd: begin
        Y      = sum[31:0];
        c_flag = sum[32];
        v_flag = is_signed & (A[31] == B[31]) & (sum[31] != A[31]);
      end
      OpSub: begin
        Y      = diff[31:0];
        c_flag = diff[32];
        v_flag = is_signed & (A[31] != B[31]) & (diff[31] != A[31]);
      end
      OpAnd:   Y = A & B;
      OpOr:    Y = A | B;
      OpXor:   Y = A ^ B;
      OpNor:   Y = ~(A | B);
      OpSll:   Y = B << A[4:0];
      OpSrl:   Y = B >> A[4:0];
      OpSra:   Y = 32'($signed(B) >>> A[4:0]);
      OpSlt:   Y = {31'd0, lt};
      OpMult:  Y = md_res;
      OpDiv:   Y = md_res;
      OpLui:   Y = {B[15:0], 16'd0};
      OpPassA: Y = A;
      OpPassB: Y = B;
      OpCmp:   Y = {31'd0, cmp_hit};
    endcase
  end

  always_comb begin
    carryFlags        = 4'd0;
    carryFlags[FlagZ] = (Y == 32'd0);
    carryFlags[FlagN] = Y[31];
    carryFlags[FlagC] = c_flag;
    carryFlags[FlagV] = v_flag;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_alu;
  import alu_pkg::*;

  logic        Clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  operation;
  logic [1:0]  sign;
  logic [2:0]  cmpSignal;
  logic [31:0] Y, HI, LO;
  logic [3:0]  carryFlags;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [31:0] m_hi, m_lo;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  alu dut (
    .Clk        (Clk),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .operation  (operation),
    .sign       (sign),
    .cmpSignal  (cmpSignal),
    .Y          (Y),
    .HI         (HI),
    .LO         (LO),
    .carryFlags (carryFlags)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t op=%0d)", nm, act, exp, $time, operation);
    end
  endtask

  // Reference: results from integer arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] op, input logic [1:0] sg,
                                input logic [2:0] cs, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] y,
                                output logic [3:0] fl, output bit wr,
                                output logic [63:0] hilo);
    longint av, bv, sa, sb, r, q, rm;
    bit c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    av = sg[0] ? sa : longint'(a);
    bv = sg[0] ? sb : longint'(b);
    c = 0; v = 0; wr = 0; hilo = 64'd0; y = 32'd0;
    case (op)
      4'd0: begin
        r = longint'(a) + longint'(b); y = r[31:0]; c = (r >= 64'sh1_0000_0000);
        v = sg[0] && ((sa + sb) > SMax || (sa + sb) < SMin);
      end
      4'd1: begin
        y = a - b; c = (a >= b);
        v = sg[0] && ((sa - sb) > SMax || (sa - sb) < SMin);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~(a | b);
      4'd6: y = b << a[4:0];
      4'd7: y = b >> a[4:0];
      4'd8: begin r = sb >>> a[4:0]; y = r[31:0]; end
      4'd9: y = (av < bv) ? 32'd1 : 32'd0;
      4'd10: begin r = av * bv; y = r[31:0]; wr = 1; hilo = r; end
      4'd11: begin
`ifdef ALU_DIV_EN
        wr = 1;
        if (b == 32'd0) begin
          y = 32'hFFFF_FFFF; hilo = {a, 32'hFFFF_FFFF};
        end else begin
          q = av / bv; rm = av % bv; y = q[31:0]; hilo = {rm[31:0], q[31:0]};
        end
`else
        y = 32'd0;
`endif
      end
      4'd12: y = {b[15:0], 16'd0};
      4'd13: y = a;
      4'd14: y = b;
      default: begin
        case (cs)
          3'd0: y = (av == bv) ? 32'd1 : 32'd0;
          3'd1: y = (av != bv) ? 32'd1 : 32'd0;
          3'd2: y = (av <  bv) ? 32'd1 : 32'd0;
          3'd3: y = (av <= bv) ? 32'd1 : 32'd0;
          3'd4: y = (av >  bv) ? 32'd1 : 32'd0;
          3'd5: y = (av >= bv) ? 32'd1 : 32'd0;
          default: y = 32'd0;
        endcase
      end
    endcase
    fl = {(y == 32'd0), y[31], c, v};
  endfunction

  logic [31:0] u_y;
  logic [3:0]  u_fl;
  bit          u_wr;
  logic [63:0] u_hilo;

  always @(posedge Clk) begin
    model(operation, sign, cmpSignal, A, B, u_y, u_fl, u_wr, u_hilo);
    if (reset) begin
      m_hi <= 32'd0;
      m_lo <= 32'd0;
    end else if (u_wr) begin
      m_hi <= u_hilo[63:32];
      m_lo <= u_hilo[31:0];
    end
  end

  logic [31:0] c_y;
  logic [3:0]  c_fl;
  bit          c_wr;
  logic [63:0] c_hilo;

  always @(negedge Clk) begin
    if (started) begin
      model(operation, sign, cmpSignal, A, B, c_y, c_fl, c_wr, c_hilo);
      chk("model_Y", {32'd0, Y}, {32'd0, c_y});
      chk("model_flags", {60'd0, carryFlags}, {60'd0, c_fl});
      chk("model_HI", {32'd0, HI}, {32'd0, m_hi});
      chk("model_LO", {32'd0, LO}, {32'd0, m_lo});
    end
  end

  task automatic drive(input logic [3:0] op, input logic [1:0] sg, input logic [2:0] cs,
                       input logic [31:0] a, input logic [31:0] b, input logic rst);
    @(posedge Clk);
    #1;
    operation = op; sign = sg; cmpSignal = cs; A = a; B = b; reset = rst;
    #1;
  endtask

  logic [31:0] pa [6];
  logic [31:0] pb [6];

  initial begin
    reset = 1'b1; operation = 4'd0; sign = 2'b00; cmpSignal = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge Clk);
    #1;
    reset = 1'b0;
    started = 1'b1;
    chk("reset_HI", {32'd0, HI}, 64'd0);
    chk("reset_LO", {32'd0, LO}, 64'd0);

    drive(OpAdd, 2'b01, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    chk("add_ovf_Y", {32'd0, Y}, 64'h8000_0000);
    chk("add_ovf_flags", {60'd0, carryFlags}, 64'b0101);

    drive(OpSub, 2'b01, 3'd0, 32'd5, 32'd5, 1'b0);
    chk("sub_eq_Y", {32'd0, Y}, 64'd0);
    chk("sub_eq_flags", {60'd0, carryFlags}, 64'b1010);

    drive(OpSub, 2'b00, 3'd0, 32'd3, 32'd5, 1'b0);
    chk("sub_borrow_Y", {32'd0, Y}, 64'hFFFF_FFFE);
    chk("sub_borrow_flags", {60'd0, carryFlags}, 64'b0100);

    drive(OpCmp, 2'b01, 3'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("cmp_lt_signed", {32'd0, Y}, 64'd1);
    drive(OpCmp, 2'b00, 3'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
    chk("cmp_lt_unsigned", {32'd0, Y}, 64'd0);
    chk("cmp_lt_unsigned_flags", {60'd0, carryFlags}, 64'b1000);

    drive(OpMult, 2'b01, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("mult_Y", {32'd0, Y}, 64'hFFFF_FFEB);
    drive(OpAdd, 2'b00, 3'd0, 32'd1, 32'd2, 1'b0);
    chk("mult_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    drive(OpAdd, 2'b00, 3'd0, 32'd3, 32'd4, 1'b0);
    chk("add_holds_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

    drive(OpDiv, 2'b01, 3'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef ALU_DIV_EN
    chk("div_Y", {32'd0, Y}, 64'hFFFF_FFFD);
`else
    chk("div_off_Y", {32'd0, Y}, 64'd0);
`endif
    drive(OpPassA, 2'b00, 3'd0, 32'd9, 32'd0, 1'b0);
`ifdef ALU_DIV_EN
    chk("div_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    chk("div_off_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif

    drive(OpDiv, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 1'b0);
`ifdef ALU_DIV_EN
    chk("div0_Y", {32'd0, Y}, 64'hFFFF_FFFF);
`else
    chk("div0_off_flags", {60'd0, carryFlags}, 64'b1000);
`endif
    drive(OpPassB, 2'b00, 3'd0, 32'd0, 32'd1, 1'b0);
`ifdef ALU_DIV_EN
    chk("div0_HILO", {HI, LO}, 64'h1234_5678_FFFF_FFFF);
`else
    chk("div0_off_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif

    drive(OpMult, 2'b01, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
    chk("reset_mult_Y", {32'd0, Y}, 64'hFFFF_FFEB);
    drive(OpAdd, 2'b00, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("reset_over_mult_HILO", {HI, LO}, 64'd0);

    drive(OpSra, 2'b00, 3'd0, 32'd4, 32'h8000_0000, 1'b0);
    chk("sra_Y", {32'd0, Y}, 64'hF800_0000);

    pa[0] = 32'd0;         pb[0] = 32'd0;
    pa[1] = 32'd5;         pb[1] = 32'd5;
    pa[2] = 32'hFFFF_FFF9; pb[2] = 32'd2;
    pa[3] = 32'h7FFF_FFFF; pb[3] = 32'hFFFF_FFFF;
    pa[4] = 32'h1234_5678; pb[4] = 32'h9ABC_DEF0;
    pa[5] = 32'h8000_0000; pb[5] = 32'hFFFF_FFFF;
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < 2; s++) begin
        for (int p = 0; p < 6; p++) begin
          drive(4'(op), 2'(s), 3'(p + s * 3 + op), pa[p], pb[p], 1'b0);
        end
      end
    end

    @(posedge Clk);
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Clk  input  1  rising-edge clock; updates HI/LO only.
REQ-003 reset  input  1  synchronous, active-high; clears HI/LO.
REQ-004 A  input  32  operand A (register-file RS).
REQ-005 B  input  32  operand B (RT, imm, MDR or PC via mux).
REQ-006 operation  input  4  operation select (REQ-010).
REQ-007 sign  input  2  bit0: 1 = signed, 0 = unsigned; bit1 reserved and ignored.
REQ-008 cmpSignal  input  3  comparison condition for CMP (REQ-012).
REQ-009 Y  output 32  combinational result; HI/LO output 32 each, registered; carryFlags output 4 = {Z,N,C,V} (bit3..bit0), combinational.

Function
REQ-010 Opcodes SHALL be:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOR
- 6 SLL (B<<A[4:0]); 7 SRL (B>>A[4:0]); 8 SRA (B>>>A[4:0])
- 9 SLT; 10 MULT; 11 DIV; 12 LUI (B[15:0]<<16)
- 13 PASSA; 14 PASSB; 15 CMP
REQ-011 SLT SHALL set Y=1 if A<B, else 0; the comparison is signed or unsigned per sign[0].
REQ-012 CMP SHALL set Y=32'd1 when the condition holds, else 0, with signedness per sign[0]. Conditions: 000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE; 110/111 give Y=0.
REQ-013 ADD/SUB SHALL wrap modulo 2^32.
REQ-014 Flags:
- C = carry-out of A+B (ADD) or of A+~B+1 (SUB; 1 = no borrow); 0 for other ops.
- V = signed overflow for ADD/SUB when sign[0]=1, else 0.
- Z = (Y==0); N = Y[31].
REQ-015 MULT SHALL latch {HI,LO} = 64-bit product (signed per sign[0]) on the next rising Clk; Y SHALL show the product low word combinationally.
REQ-016 DIV SHALL latch LO=quotient and HI=remainder (truncating toward zero; the remainder takes the sign of A) on the next rising Clk; Y SHALL show the quotient.
REQ-017 For DIV with B==0: LO=32'hFFFFFFFF, HI=A, Y=32'hFFFFFFFF; no other flag or trap.
REQ-018 HI/LO SHALL hold their value for all opcodes other than MULT/DIV; Y latency SHALL be 0 cycles, HI/LO latency 1 cycle.
REQ-019 No undefined outputs: X-free inputs SHALL give X-free Y, flags, HI and LO.

Reset
REQ-020 On a rising Clk with reset=1, HI and LO SHALL become 0, overriding MULT/DIV in the same cycle.
REQ-021 Y and carryFlags SHALL be unaffected by reset (purely combinational).

Configuration
REQ-022 With ALU_DIV_EN defined, DIV SHALL behave per REQ-016/017.
REQ-023 With ALU_DIV_EN undefined, opcode 11 SHALL give Y=0 and leave HI/LO unchanged, with flags computed from Y.

Structure
REQ-024 Package alu_pkg SHALL hold the opcode constants, cmpSignal codes and flag bit indices.
REQ-025 Sub-module alu_muldiv SHALL hold the multiply/divide datapath and the HI/LO registers; the top level holds the combinational ops and flags.

Verification
REQ-026 The bench SHALL cover these scenarios:
- ADD, sign=01, A=32'h7FFFFFFF, B=1 -> Y=32'h80000000, flags V=1, N=1, Z=0, C=0.
- SUB, A=5, B=5 -> Y=0, Z=1, C=1; SUB unsigned, A=3, B=5 -> Y=32'hFFFFFFFE, C=0.
- CMP LT, A=32'hFFFFFFFF, B=1 -> Y=1 with sign=01; Y=0 with sign=00.
- MULT, sign=01, A=-3, B=7, then Clk -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; next op ADD leaves HI/LO unchanged.
- DIV, A=-7, B=2 -> LO=-3, HI=-1; DIV with B=0 -> LO=32'hFFFFFFFF, HI=A.
- reset=1 together with MULT, then Clk -> HI=LO=0; SRA, A=4, B=32'h80000000 -> Y=32'hF8000000.
